digitally_controlled_oscillator: RTL and testbench

//  Generates the ADPLL output clock: the signal the phase detector samples as its generated input.

---
 rtl/digitally_controlled_oscillator.sv | 213 +++++++++++++++++++++
 tb/tb_digitally_controlled_oscillator.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digitally_controlled_oscillator.sv
// Digitally controlled oscillator for the ADPLL.
// Square-wave output whose half-period is a fixed-point count {N,F} of fpga_clk_i
// cycles. A fractional accumulator dithers each half-period between N and N+1.
// New control words are double-buffered and commit only at a rising edge.
// Optional feature macro: DCO_PHASE_STEP_EN adds a signed one-shot adjust of the
// next LOW half-period (ports phase_step_i / step_valid_i).
//
// state | meaning
// IDLE  | stopped, output 0, fractional accumulator cleared
// HIGH  | output 1, down-counter running for the current half-period
// LOW   | output 0, down-counter running; at terminal count rise again or stop
module digitally_controlled_oscillator #(
    parameter int               WIDTH           = 20,
    parameter int               FRAC_BITS       = 8,
    parameter int               MIN_HALF_PERIOD = 2,
    parameter logic [WIDTH-1:0] RESET_WORD      = 20'h00A00
`ifdef DCO_PHASE_STEP_EN
    ,parameter int              PSTEP_WIDTH     = 8
`endif
) (
    input  logic                          fpga_clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [WIDTH-1:0]              ctrl_word_i,
    input  logic                          load_i,
`ifdef DCO_PHASE_STEP_EN
    input  logic signed [PSTEP_WIDTH-1:0] phase_step_i,
    input  logic                          step_valid_i,
`endif
    output logic                          generated_o,
    output logic                          rise_pulse_o,
    output logic                          update_ack_o
);

    localparam int NW = WIDTH - FRAC_BITS;
`ifdef DCO_PHASE_STEP_EN
    localparam int CW = ((NW > PSTEP_WIDTH) ? NW : PSTEP_WIDTH) + 2;
`else
    localparam int CW = NW + 2;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAC_BITS-1:0] frac_acc_q, frac_acc_d;
    logic [WIDTH-1:0]     active_q, active_d;
    logic [WIDTH-1:0]     pending_q, pending_d;
    logic                 upd_flag_q, upd_flag_d;
    logic                 gen_q, gen_d;
    logic                 rise_q, rise_d;
    logic                 ack_q, ack_d;
`ifdef DCO_PHASE_STEP_EN
    logic signed [PSTEP_WIDTH-1:0] step_q, step_d;
    logic                          step_pend_q, step_pend_d;
`endif

    logic                 half_done;
    logic                 start_high;
    logic                 start_low;
    logic                 commit;
    logic [WIDTH-1:0]     word_sel;
    logic [NW-1:0]        n_eff;
    logic [FRAC_BITS-1:0] f_eff;
    logic [FRAC_BITS:0]   frac_sum;
    int                   half_len;
    logic [CW-1:0]        cnt_load;

    // A rising edge may start from IDLE or from the end of LOW; either one commits a flagged word.
    assign half_done  = (cnt_q == '0);
    assign start_high = enable_i && ((state_q == IDLE) || ((state_q == LOW) && half_done));
    assign start_low  = (state_q == HIGH) && half_done;
    assign commit     = start_high && upd_flag_q;

    // Length of the half-period about to start, from the word that will be active during it.
    always_comb begin
        word_sel = commit ? pending_q : active_q;
        n_eff    = word_sel[WIDTH-1:FRAC_BITS];
        f_eff    = word_sel[FRAC_BITS-1:0];
        if (n_eff < NW'(MIN_HALF_PERIOD)) begin
            n_eff = NW'(MIN_HALF_PERIOD);
            f_eff = '0;
        end
        frac_sum = {1'b0, frac_acc_q} + {1'b0, f_eff};
        half_len = int'(n_eff) + int'(frac_sum[FRAC_BITS]);
`ifdef DCO_PHASE_STEP_EN
        if (start_low && step_pend_q) begin
            half_len = half_len + int'(step_q);
        end
`endif
        if (half_len < MIN_HALF_PERIOD) begin
            half_len = MIN_HALF_PERIOD;
        end
        cnt_load = CW'(half_len - 1);
    end

    // Next-state, down-counter and output flops of the oscillator FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frac_acc_d = frac_acc_q;
        active_d   = active_q;
        gen_d      = gen_q;
        rise_d     = 1'b0;
        ack_d      = 1'b0;
        if (start_high) begin
            state_d    = HIGH;
            gen_d      = 1'b1;
            rise_d     = 1'b1;
            cnt_d      = cnt_load;
            frac_acc_d = frac_sum[FRAC_BITS-1:0];
            if (commit) begin
                active_d = pending_q;
                ack_d    = 1'b1;
            end
        end else begin
            case (state_q)
                HIGH: begin
                    if (start_low) begin
                        state_d    = LOW;
                        gen_d      = 1'b0;
                        cnt_d      = cnt_load;
                        frac_acc_d = frac_sum[FRAC_BITS-1:0];
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                LOW: begin
                    if (half_done) begin
                        state_d    = IDLE;
                        gen_d      = 1'b0;
                        frac_acc_d = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    gen_d   = 1'b0;
                end
            endcase
        end
    end

    // Pending word: last load wins; a load coinciding with a commit stays flagged for the next edge.
    always_comb begin
        pending_d  = pending_q;
        upd_flag_d = upd_flag_q;
        if (load_i) begin
            pending_d  = ctrl_word_i;
            upd_flag_d = 1'b1;
        end else if (commit) begin
            upd_flag_d = 1'b0;
        end
    end

`ifdef DCO_PHASE_STEP_EN
    // One-shot phase step: held until the next LOW half-period consumes it.
    always_comb begin
        step_d      = step_q;
        step_pend_d = step_pend_q;
        if (step_valid_i) begin
            step_d      = phase_step_i;
            step_pend_d = 1'b1;
        end else if (start_low) begin
            step_d      = '0;
            step_pend_d = 1'b0;
        end
    end
`endif

    // State register; reset drops the output at once, abandoning any half-period.
    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frac_acc_q  <= '0;
            active_q    <= RESET_WORD;
            pending_q   <= RESET_WORD;
            upd_flag_q  <= 1'b0;
            gen_q       <= 1'b0;
            rise_q      <= 1'b0;
            ack_q       <= 1'b0;
`ifdef DCO_PHASE_STEP_EN
            step_q      <= '0;
            step_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frac_acc_q  <= frac_acc_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            upd_flag_q  <= upd_flag_d;
            gen_q       <= gen_d;
            rise_q      <= rise_d;
            ack_q       <= ack_d;
`ifdef DCO_PHASE_STEP_EN
            step_q      <= step_d;
            step_pend_q <= step_pend_d;
`endif
        end
    end

    assign generated_o  = gen_q;
    assign rise_pulse_o = rise_q;
    assign update_ack_o = ack_q;

endmodule

// File: tb/tb_digitally_controlled_oscillator.sv
// Bench for digitally_controlled_oscillator: measures high/low run lengths of the
// output and compares them with a period-level model of the control word rules.
`timescale 1ns/1ps
module tb_digitally_controlled_oscillator;
    localparam int          MINH       = 2;
    localparam logic [19:0] RESET_WORD = 20'h00A00;

    logic        clk_sys = 1'b0;
    logic        rst_b;
    logic        enable_i;
    logic        load_i;
    logic [19:0] ctrl_word_i;
    logic        generated_o;
    logic        rise_pulse_o;
    logic        update_ack_o;
`ifdef DCO_PHASE_STEP_EN
    logic signed [7:0] phase_step_i;
    logic              step_valid_i;
`endif

    int errors = 0;
    int checks = 0;

    // Period-level model of the control word double buffer and fractional dither.
    logic [19:0] m_active, m_pending, m_deferred;
    bit          m_flag, m_def_valid, m_step_valid;
    int          m_acc, m_step;

    always #5 clk_sys = ~clk_sys;

    digitally_controlled_oscillator dut (
        .fpga_clk_i   (clk_sys),
        .reset_i      (rst_b),
        .enable_i     (enable_i),
        .ctrl_word_i  (ctrl_word_i),
        .load_i       (load_i),
`ifdef DCO_PHASE_STEP_EN
        .phase_step_i (phase_step_i),
        .step_valid_i (step_valid_i),
`endif
        .generated_o  (generated_o),
        .rise_pulse_o (rise_pulse_o),
        .update_ack_o (update_ack_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_active = RESET_WORD; m_pending = RESET_WORD; m_deferred = '0;
        m_flag = 0; m_def_valid = 0; m_acc = 0; m_step = 0; m_step_valid = 0;
    endtask

    // Half-period length: N plus the carry out of the fractional phase accumulator.
    function automatic int m_half(input logic [19:0] w, input int step);
        int n, f, s, l;
        n = int'(w[19:8]);
        f = int'(w[7:0]);
        if (n < MINH) begin n = MINH; f = 0; end
        s = m_acc + f;
        m_acc = s % 256;
        l = n + s / 256 + step;
        if (l < MINH) l = MINH;
        return l;
    endfunction

    task automatic m_start_period(output int ehi, output int elo, output bit eack);
        eack = m_flag;
        if (m_flag) begin m_active = m_pending; m_flag = 0; end
        if (m_def_valid) begin m_pending = m_deferred; m_flag = 1; m_def_valid = 0; end
        ehi = m_half(m_active, 0);
        elo = m_half(m_active, m_step_valid ? m_step : 0);
        m_step_valid = 0;
    endtask

    // A load in the final LOW cycle lands on the same edge as the next commit.
    task automatic m_load(input logic [19:0] w, input bit on_commit_edge);
        if (on_commit_edge) begin m_deferred = w; m_def_valid = 1; end
        else begin m_pending = w; m_flag = 1; end
    endtask

    task automatic m_apply_loads(input int a1, input logic [19:0] w1, input int a2, input logic [19:0] w2, input int last);
        if (a1 >= 0) m_load(w1, a1 == last);
        if (a2 >= 0) m_load(w2, a2 == last);
    endtask

    task automatic drive_at(input int cyc, input int a1, input logic [19:0] w1, input int a2, input logic [19:0] w2,
                            input int dis_at, input int en_at);
        if (cyc == a1) begin load_i = 1'b1; ctrl_word_i = w1; end
        if (cyc == a2) begin load_i = 1'b1; ctrl_word_i = w2; end
        if (cyc == dis_at) enable_i = 1'b0;
        if (cyc == en_at)  enable_i = 1'b1;
    endtask

    // Called at the sample of a rising-edge cycle; returns at the next one (or after max_lo low cycles).
    task automatic measure_period(input int a1, input logic [19:0] w1, input int a2, input logic [19:0] w2,
                                  input int dis_at, input int en_at, input int max_lo,
                                  output int hi, output int lo, output bit rise0, output bit ack0, output int spur);
        int cyc;
        rise0 = rise_pulse_o; ack0 = update_ack_o;
        hi = 1; lo = 0; spur = 0; cyc = 0;
        drive_at(0, a1, w1, a2, w2, dis_at, en_at);
        while (cyc < 5000) begin
            @(negedge clk_sys);
            cyc++;
            load_i = 1'b0;
`ifdef DCO_PHASE_STEP_EN
            step_valid_i = 1'b0;
`endif
            if (generated_o === 1'b1) begin
                if (lo != 0) break;
                hi++;
            end else begin
                lo++;
                if (lo >= max_lo) break;
            end
            if (rise_pulse_o !== 1'b0 || update_ack_o !== 1'b0) spur++;
            drive_at(cyc, a1, w1, a2, w2, dis_at, en_at);
        end
        load_i = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (generated_o !== 1'b0 || rise_pulse_o !== 1'b0 || update_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gen=%b rise=%b ack=%b, expected 0 0 0", generated_o, rise_pulse_o, update_ack_o);
        end
        rst_b = 1'b1;
        bad = 0;
        repeat (4) begin @(negedge clk_sys); if (generated_o !== 1'b0 || rise_pulse_o !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_after_reset: %0d active cycles, expected 0", bad); end
    endtask

    task automatic test_default();
        int ehi, elo, hi, lo, spur; bit eack, rise0, ack0;
        enable_i = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (generated_o !== 1'b1 || rise_pulse_o !== 1'b1) begin
            errors++; $display("FAIL enable_latency: gen=%b rise=%b one cycle after enable, expected 1 1", generated_o, rise_pulse_o);
        end
        for (int p = 0; p < 3; p++) begin
            m_start_period(ehi, elo, eack);
            measure_period(-1, '0, -1, '0, -1, -1, 100000, hi, lo, rise0, ack0, spur);
            checks++;
            if (hi !== ehi || lo !== elo) begin errors++;
                $display("FAIL default_period p=%0d: high=%0d low=%0d, expected high=%0d low=%0d", p, hi, lo, ehi, elo); end
            checks++;
            if (rise0 !== 1'b1 || ack0 !== eack || spur !== 0) begin errors++;
                $display("FAIL default_pulses p=%0d: rise=%b ack=%b stray=%0d, expected rise=1 ack=%b stray=0", p, rise0, ack0, spur, eack); end
        end
    endtask

    task automatic test_fractional();
        int ehi, elo, hi, lo, spur, a1; bit eack, rise0, ack0;
        for (int p = 0; p < 4; p++) begin
            m_start_period(ehi, elo, eack);
            a1 = (p == 0) ? 3 : -1;
            measure_period(a1, 20'h00A80, -1, '0, -1, -1, 100000, hi, lo, rise0, ack0, spur);
            checks++;
            if (hi !== ehi || lo !== elo) begin errors++;
                $display("FAIL frac_period p=%0d: high=%0d low=%0d, expected high=%0d low=%0d", p, hi, lo, ehi, elo); end
            checks++;
            if (rise0 !== 1'b1 || ack0 !== eack || spur !== 0) begin errors++;
                $display("FAIL frac_pulses p=%0d: rise=%b ack=%b stray=%0d, expected rise=1 ack=%b stray=0", p, rise0, ack0, spur, eack); end
            m_apply_loads(a1, 20'h00A80, -1, '0, ehi + elo - 1);
        end
    endtask

    // -2 in the offset tables means "the last LOW cycle", i.e. the same edge as the next commit.
    task automatic test_update();
        int ehi, elo, hi, lo, spur, a1, a2, last; bit eack, rise0, ack0;
        int          t_a1[6] = '{2, 4, 1, 2, -1, -1};
        logic [19:0] t_w1[6] = '{20'h00A00, 20'h00600, 20'h00300, 20'h00500, 20'h0, 20'h0};
        int          t_a2[6] = '{-1, -1, 5, -2, -1, -1};
        logic [19:0] t_w2[6] = '{20'h0, 20'h0, 20'h00800, 20'h00700, 20'h0, 20'h0};
        for (int p = 0; p < 6; p++) begin
            m_start_period(ehi, elo, eack);
            last = ehi + elo - 1;
            a1 = (t_a1[p] == -2) ? last : t_a1[p];
            a2 = (t_a2[p] == -2) ? last : t_a2[p];
            measure_period(a1, t_w1[p], a2, t_w2[p], -1, -1, 100000, hi, lo, rise0, ack0, spur);
            checks++;
            if (hi !== ehi || lo !== elo) begin errors++;
                $display("FAIL update_period p=%0d: high=%0d low=%0d, expected high=%0d low=%0d", p, hi, lo, ehi, elo); end
            checks++;
            if (rise0 !== 1'b1 || ack0 !== eack || spur !== 0) begin errors++;
                $display("FAIL update_pulses p=%0d: rise=%b ack=%b stray=%0d, expected rise=1 ack=%b stray=0", p, rise0, ack0, spur, eack); end
            m_apply_loads(a1, t_w1[p], a2, t_w2[p], last);
        end
    endtask

    task automatic test_clamp();
        int ehi, elo, hi, lo, spur, a1; bit eack, rise0, ack0;
        for (int p = 0; p < 4; p++) begin
            m_start_period(ehi, elo, eack);
            a1 = (p == 0) ? 1 : -1;
            measure_period(a1, 20'h00140, -1, '0, -1, -1, 100000, hi, lo, rise0, ack0, spur);
            checks++;
            if (hi !== ehi || lo !== elo) begin errors++;
                $display("FAIL clamp_period p=%0d: high=%0d low=%0d, expected high=%0d low=%0d", p, hi, lo, ehi, elo); end
            checks++;
            if (rise0 !== 1'b1 || ack0 !== eack || spur !== 0) begin errors++;
                $display("FAIL clamp_pulses p=%0d: rise=%b ack=%b stray=%0d, expected rise=1 ack=%b stray=0", p, rise0, ack0, spur, eack); end
            m_apply_loads(a1, 20'h00140, -1, '0, ehi + elo - 1);
        end
    endtask

    task automatic test_random();
        int ehi, elo, hi, lo, spur, a1, a2, last; bit eack, rise0, ack0; logic [19:0] w1, w2;
        for (int p = 0; p < 12; p++) begin
            m_start_period(ehi, elo, eack);
            last = ehi + elo - 1;
            w1 = (20'($urandom_range(14, 1)) << 8) | 20'($urandom_range(255, 0));
            w2 = (20'($urandom_range(14, 1)) << 8) | 20'($urandom_range(255, 0));
            a1 = int'($urandom_range(last, 0));
            a2 = -1;
            if (a1 < last && $urandom_range(1, 0) == 1) a2 = int'($urandom_range(last, a1 + 1));
            measure_period(a1, w1, a2, w2, -1, -1, 100000, hi, lo, rise0, ack0, spur);
            checks++;
            if (hi !== ehi || lo !== elo) begin errors++;
                $display("FAIL random_period p=%0d: high=%0d low=%0d, expected high=%0d low=%0d", p, hi, lo, ehi, elo); end
            checks++;
            if (rise0 !== 1'b1 || ack0 !== eack || spur !== 0) begin errors++;
                $display("FAIL random_pulses p=%0d: rise=%b ack=%b stray=%0d, expected rise=1 ack=%b stray=0", p, rise0, ack0, spur, eack); end
            m_apply_loads(a1, w1, a2, w2, last);
        end
    endtask

    task automatic test_disable();
        int ehi, elo, hi, lo, spur; bit eack, rise0, ack0;
        // settle on N=5
        m_start_period(ehi, elo, eack);
        measure_period(1, 20'h00500, -1, '0, -1, -1, 100000, hi, lo, rise0, ack0, spur);
        m_apply_loads(1, 20'h00500, -1, '0, ehi + elo - 1);
        // stop mid-HIGH: the whole period completes, then the output stays low
        m_start_period(ehi, elo, eack);
        measure_period(-1, '0, -1, '0, 2, -1, 40, hi, lo, rise0, ack0, spur);
        checks++;
        if (hi !== ehi || lo !== 40 || spur !== 0) begin errors++;
            $display("FAIL graceful_stop: high=%0d low_run=%0d stray=%0d, expected high=%0d low_run=40 stray=0", hi, lo, spur, ehi); end
        m_acc = 0;
        // a word loaded while idle commits on the restart edge
        load_i = 1'b1; ctrl_word_i = 20'h00300;
        m_load(20'h00300, 0);
        @(negedge clk_sys);
        load_i = 1'b0; enable_i = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (generated_o !== 1'b1 || rise_pulse_o !== 1'b1) begin errors++;
            $display("FAIL restart_latency: gen=%b rise=%b, expected 1 1", generated_o, rise_pulse_o); end
        // drop and restore enable before LOW ends: no gap
        for (int p = 0; p < 2; p++) begin
            m_start_period(ehi, elo, eack);
            measure_period(-1, '0, -1, '0, (p == 0) ? 1 : -1, (p == 0) ? ehi + 1 : -1, 100000, hi, lo, rise0, ack0, spur);
            checks++;
            if (hi !== ehi || lo !== elo) begin errors++;
                $display("FAIL reenable_period p=%0d: high=%0d low=%0d, expected high=%0d low=%0d", p, hi, lo, ehi, elo); end
            checks++;
            if (rise0 !== 1'b1 || ack0 !== eack || spur !== 0) begin errors++;
                $display("FAIL reenable_pulses p=%0d: rise=%b ack=%b stray=%0d, expected rise=1 ack=%b stray=0", p, rise0, ack0, spur, eack); end
        end
    endtask

    task automatic test_reset_mid();
        int ehi, elo, hi, lo, spur, bad; bit eack, rise0, ack0;
        load_i = 1'b1; ctrl_word_i = 20'h00700;
        @(negedge clk_sys);
        load_i = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (generated_o !== 1'b1) begin errors++; $display("FAIL pre_reset_high: gen=%b, expected 1", generated_o); end
        rst_b = 1'b0;
        #1;
        checks++;
        if (generated_o !== 1'b0 || rise_pulse_o !== 1'b0 || update_ack_o !== 1'b0) begin errors++;
            $display("FAIL async_reset: gen=%b rise=%b ack=%b, expected 0 0 0", generated_o, rise_pulse_o, update_ack_o); end
        enable_i = 1'b0;
        m_reset();
        repeat (2) @(negedge clk_sys);
        rst_b = 1'b1;
        bad = 0;
        repeat (3) begin @(negedge clk_sys); if (generated_o !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_idle: %0d high cycles, expected 0", bad); end
        enable_i = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (generated_o !== 1'b1 || rise_pulse_o !== 1'b1) begin errors++;
            $display("FAIL post_reset_start: gen=%b rise=%b, expected 1 1", generated_o, rise_pulse_o); end
        m_start_period(ehi, elo, eack);
        measure_period(-1, '0, -1, '0, -1, -1, 100000, hi, lo, rise0, ack0, spur);
        checks++;
        if (hi !== ehi || lo !== elo || ack0 !== eack) begin errors++;
            $display("FAIL post_reset_period: high=%0d low=%0d ack=%b, expected high=%0d low=%0d ack=%b", hi, lo, ack0, ehi, elo, eack); end
    endtask

`ifdef DCO_PHASE_STEP_EN
    task automatic test_phase_step();
        int ehi, elo, hi, lo, spur; bit eack, rise0, ack0;
        int steps[6] = '{-3, 0, -9, 0, 4, 0};
        for (int p = 0; p < 6; p++) begin
            if (steps[p] != 0) begin
                m_step = steps[p]; m_step_valid = 1;
                phase_step_i = 8'(steps[p]); step_valid_i = 1'b1;
            end
            m_start_period(ehi, elo, eack);
            measure_period(-1, '0, -1, '0, -1, -1, 100000, hi, lo, rise0, ack0, spur);
            checks++;
            if (hi !== ehi || lo !== elo) begin errors++;
                $display("FAIL step_period p=%0d: high=%0d low=%0d, expected high=%0d low=%0d", p, hi, lo, ehi, elo); end
        end
    endtask
`endif

    initial begin
        rst_b = 1'b0; enable_i = 1'b0; load_i = 1'b0; ctrl_word_i = '0;
`ifdef DCO_PHASE_STEP_EN
        phase_step_i = '0; step_valid_i = 1'b0;
`endif
        m_reset();
        test_reset();
        test_default();
        test_fractional();
        test_update();
        test_clamp();
        test_random();
        test_disable();
        test_reset_mid();
`ifdef DCO_PHASE_STEP_EN
        test_phase_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
